// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU.
// Single-cycle arithmetic, logic and shift ops, plus an optional iterative
// shift-add multiplier behind a start/busy/done handshake. The result and
// the NZCV flags are registered and only change on a done edge.
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             negative_flag,
    output logic             overflow_flag
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ORR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_LSL = 4'b0111;
    localparam logic [3:0] OP_LSR = 4'b1000;
    localparam logic [3:0] OP_ASR = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state, state_nxt;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] b_op;
    logic             cin_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl, shr, sar;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v;
    logic             mul_go;
    logic             sc_load, mul_fin;
    logic [WIDTH-1:0] mul_res;
    logic             mul_last;

    // Only the low bits of b select the shift distance.
    assign sh     = b[SH_W-1:0];
    assign mul_go = start && (alu_control == OP_MUL) && (MUL_EN != 1'b0);
    assign busy   = (state == S_MUL);

    // Shared adder: subtraction is a + ~b + cin so the carry out is NOT borrow.
    // Shifters carry one extra bit to catch the last bit shifted out.
    always_comb begin
        b_op   = b;
        cin_op = 1'b0;
        case (alu_control)
            OP_SUB:  begin b_op = ~b; cin_op = 1'b1;     end
            OP_ADC:  begin            cin_op = carry_in; end
            OP_SBC:  begin b_op = ~b; cin_op = carry_in; end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};
        shl = {1'b0, a} << sh;
        shr = {a, 1'b0} >> sh;
        sar = $signed({a, 1'b0}) >>> sh;
    end

    // Single-cycle result and flag candidates; untouched flags keep their value.
    always_comb begin
        alu_r = a;
        alu_c = carry_flag;
        alu_v = overflow_flag;
        case (alu_control)
            OP_ADD, OP_ADC: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] ^ alu_r[WIDTH-1]) & (b[WIDTH-1] ^ alu_r[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ alu_r[WIDTH-1]);
            end
            OP_ORR: alu_r = a | b;
            OP_AND: alu_r = a & b;
            OP_EOR: alu_r = a ^ b;
            OP_LSL: begin
                alu_r = shl[WIDTH-1:0];
                if (sh != '0) alu_c = shl[WIDTH];
            end
            OP_LSR: begin
                alu_r = shr[WIDTH:1];
                if (sh != '0) alu_c = shr[0];
            end
            OP_ASR: begin
                alu_r = sar[WIDTH:1];
                if (sh != '0) alu_c = sar[0];
            end
            default: alu_r = a;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state: starts are honoured only in IDLE; MUL leaves after its last step.
    always_comb begin
        state_nxt = state;
        sc_load   = 1'b0;
        mul_fin   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (mul_go) state_nxt = S_MUL;
                    else        sc_load   = 1'b1;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_IDLE;
                    mul_fin   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            logic [WIDTH-1:0] mcand, mplr, acc, acc_step;
            logic [SH_W-1:0]  cnt;

            // The last step's sum feeds the result directly, saving a cycle.
            assign acc_step = acc + (mplr[0] ? mcand : '0);
            assign mul_res  = acc_step;
            assign mul_last = (state == S_MUL) && (cnt == SH_W'(WIDTH - 1));

            // One shift-add step per cycle; only the low WIDTH product bits are kept.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mcand <= '0;
                    mplr  <= '0;
                    acc   <= '0;
                    cnt   <= '0;
                end else if (state == S_IDLE && mul_go) begin
                    mcand <= a;
                    mplr  <= b;
                    acc   <= '0;
                    cnt   <= '0;
                end else if (state == S_MUL) begin
                    acc   <= acc_step;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + SH_W'(1);
                end
            end
        end else begin : g_nomul
            assign mul_res  = '0;
            assign mul_last = 1'b0;
        end
    endgenerate

    // Result/flag registers: written only on the edge that also raises done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done          <= 1'b0;
            result        <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            done <= sc_load | mul_fin;
            if (sc_load) begin
                result        <= alu_r;
                negative_flag <= alu_r[WIDTH-1];
                zero_flag     <= (alu_r == '0);
                carry_flag    <= alu_c;
                overflow_flag <= alu_v;
            end else if (mul_fin) begin
                result        <= mul_res;
                negative_flag <= mul_res[WIDTH-1];
                zero_flag     <= (mul_res == '0);
            end
        end
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath, replacing the fixed 8-bit combinational unit. It supports ARM-style carry-in arithmetic, shifts and an iterative multiplier behind a start/busy/done handshake. Result and NZCV flags are registered and hold until the next operation completes. It sits between the register file read ports and the writeback mux; the controller stalls on `busy`.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two, 8..64.
- `MUL_EN`, default 1: 1 = iterative multiplier present; 0 = opcode MUL behaves as an undefined opcode.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: launch operation; sampled only when idle.
- `alu_control` in 4: opcode, sampled with `start`.
- `a`, `b` in WIDTH: operands, sampled with `start`.
- `carry_in` in 1: C input for ADC/SBC, sampled with `start`.
- `busy` out 1: multiply in progress.
- `done` out 1: one-cycle pulse; result and flags were updated on the same edge.
- `result` out WIDTH: registered result.
- `zero_flag`, `carry_flag`, `negative_flag`, `overflow_flag` out 1: registered NZCV.

## Operation
- Opcodes:
  - 0000 ADD: a+b
  - 0001 SUB: a−b
  - 0010 ORR
  - 0011 AND
  - 0100 EOR
  - 0101 ADC: a+b+carry_in
  - 0110 SBC: a−b−(1−carry_in)
  - 0111 LSL, 1000 LSR, 1001 ASR: shift a by sh = b[$clog2(WIDTH)−1:0]
  - 1010 MUL: low WIDTH bits of a×b, unsigned
  - 1011..1111: pass a
- N = result[WIDTH−1]; Z = (result == 0). Both are updated by every operation.
- C by opcode:
  - ADD/ADC: carry out of bit WIDTH−1.
  - SUB/SBC: NOT borrow (ARM convention). C=1 when a ≥ b (+borrow) unsigned.
  - Shifts: last bit shifted out. Unchanged when sh = 0.
  - Logic, MUL, pass: unchanged.
- V by opcode:
  - ADD/ADC: msb of (a^r)&(b^r).
  - SUB/SBC: msb of (a^b)&(a^r).
  - All others: unchanged.
- FSM states are IDLE and MUL.
- IDLE + start + non-MUL opcode:
  - Compute combinationally from the sampled inputs.
  - Register result/flags and pulse `done` on the same edge.
  - Stay in IDLE.
- IDLE + start + MUL (MUL_EN=1):
  - Latch a, b; clear the accumulator; iteration counter = 0.
  - Go to MUL; `busy`=1.
- MUL state, one shift-add step per cycle (accumulator += multiplicand if multiplier lsb; multiplicand <<= 1; multiplier >>= 1).
- After WIDTH steps:
  - Write result and N/Z, pulse `done`, clear `busy`, return to IDLE.
- `start` while busy is ignored: inputs are not latched and there is no queueing.
- `result` and flags change only on `done` edges; otherwise they hold.
- MUL_EN=0: the multiplier logic is absent, and 1010 is single-cycle pass-a.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, all flags=0.
  - Any in-flight multiply is aborted and no `done` is issued.
- Single-cycle ops:
  - `start` sampled at edge k → result/flags/done valid after edge k.
  - Latency 1; `done` high for exactly one cycle.
  - Back-to-back starts on consecutive cycles are accepted; `done` stays high continuously, with a new result each cycle.
- MUL:
  - `start` at edge k → busy=1 after edge k.
  - done=1 and busy=0 after edge k+WIDTH.
  - A new `start` is accepted at edge k+WIDTH+1 at the earliest. `start` at edge k+WIDTH is ignored, since the block is still in MUL.
- `done` is never asserted while busy=1.
- Shift by sh ≥ 1 uses only the low $clog2(WIDTH) bits of b; upper bits of b are ignored.
- `carry_in` is used only by ADC/SBC; the flag registers are not fed back implicitly.

## Test plan
- All cases use WIDTH=8.
- ADD 0x7F+0x01 → one cycle later: done=1, result=0x80, N=1, Z=0, C=0, V=1. Then SUB 0x05−0x05 → 0x00, Z=1, C=1, V=0.
- SUB 0x03−0x05 → 0xFE, N=1, C=0, V=0. ADC 0xFF+0x00 with carry_in=1 → 0x00, Z=1, C=1. SBC 0x10−0x01 with carry_in=0 → 0x0E, C=1.
- LSL 0x81 by 1 → 0x02, C=1. ASR 0x80 by 3 → 0xF0, C=0. LSR 0x81 with b=0x08 (sh=0) → 0x81, C unchanged. Then ORR 0x0F|0xF0 → 0xFF, N=1, C and V retained.
- MUL 0x0D×0x0B:
  - busy high for 8 cycles, then done=1, result=0x8F, N=1, C and V retained.
  - ADD start at cycle 3 is ignored, with result unchanged until MUL done.
  - MUL 0x10×0x10 → 0x00, Z=1.
- Assert reset_n=0 in cycle 4 of a MUL:
  - All outputs go 0 immediately, and no done follows.
  - After release, ADD 0x01+0x02 → 0x03 with latency 1.
- MUL_EN=0: opcode 1010 with a=0x5A → single-cycle, result=0x5A, busy never asserted.
